// File: rtl/ship_motion_ctrl_if.sv
// rtl/ship_motion_ctrl_if.sv - keyboard-in / ship-state-out bundle for the ship motion stage
//
// Purpose: groups the per-frame key inputs and the ship state outputs of
// ship_motion_ctrl into one bundle.
// Signals:
//   keycode   [7:0]   current USB keycode (driven by master)
//   moving            sticky "game started" flag (driven by master)
//   ship_x    [WB-1:0] world X (driven by slave)
//   ship_y    [WB-1:0] world Y, 0 is the top edge (driven by slave)
//   heading   [2:0]   0=N .. 7=NW, clockwise (driven by slave)
//   speed     [3:0]   pixels/frame per axis (driven by slave)
//   thrusting         high while accelerating (driven by slave)
// Modports: master = keyboard/latch side, slave = motion controller.

interface ship_motion_ctrl_if #(
  parameter int WB = 10
);
  logic [7:0]    keycode;
  logic          moving;
  logic [WB-1:0] ship_x;
  logic [WB-1:0] ship_y;
  logic [2:0]    heading;
  logic [3:0]    speed;
  logic          thrusting;

  modport master (
    output keycode, moving,
    input  ship_x, ship_y, heading, speed, thrusting
  );

  modport slave (
    input  keycode, moving,
    output ship_x, ship_y, heading, speed, thrusting
  );
endinterface

// File: rtl/ship_motion_ctrl.sv
// rtl/ship_motion_ctrl.sv - player ship heading/speed/wrapped-position stage
//
// Purpose: once per frame_clk, turns the raw keycode and the latched moving
// flag into the ship heading, speed and wrapped world position.
// Keys: 0x04 rotate CCW, 0x07 rotate CW, 0x1A thrust, 0x16 brake.
// Ports:
//   frame_clk  in   frame-rate clock, all state changes on its rising edge
//   Reset      in   asynchronous, active-high reset
//   bus        slave modport of ship_motion_ctrl_if
//                (keycode, moving in; ship_x, ship_y, heading, speed,
//                 thrusting out, all registered)

module ship_motion_ctrl #(
  parameter int WB           = 10,
  parameter int START_X      = 512,
  parameter int START_Y      = 512,
  parameter int MAX_SPEED    = 4,
  parameter int ACCEL_FRAMES = 4,
  parameter int BRAKE_FRAMES = 2,
  parameter int DECEL_FRAMES = 8,
  parameter int TURN_FRAMES  = 6
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  ship_motion_ctrl_if.slave    bus
);

  localparam logic [7:0] KEY_CCW    = 8'h04;
  localparam logic [7:0] KEY_CW     = 8'h07;
  localparam logic [7:0] KEY_THRUST = 8'h1A;
  localparam logic [7:0] KEY_BRAKE  = 8'h16;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    COAST = 2'd1,
    ACCEL = 2'd2,
    BRAKE = 2'd3
  } state_t;

  state_t        state;
  logic [WB-1:0] ship_x_q;
  logic [WB-1:0] ship_y_q;
  logic [2:0]    heading_q;
  logic [3:0]    speed_q;
  logic          thrusting_q;
  logic [7:0]    rate_cnt;
  logic [7:0]    turn_cnt;

  // Combinational helpers for the next edge
  state_t        req_state;
  logic [7:0]    rate_last;
  logic [3:0]    spd_inc;
  logic [3:0]    spd_dec;
  logic          turn_key;
  logic [2:0]    heading_turned;
  logic [WB-1:0] spd_ext;
  logic [WB-1:0] next_x;
  logic [WB-1:0] next_y;
  logic          go_east;
  logic          go_west;
  logic          go_north;
  logic          go_south;

  always_comb begin
    req_state = COAST;
    if (bus.keycode == KEY_THRUST) begin
      req_state = ACCEL;
    end else if (bus.keycode == KEY_BRAKE) begin
      req_state = BRAKE;
    end

    // Rate period follows the state we are in now, not the requested one.
    case (state)
      ACCEL:   rate_last = 8'(ACCEL_FRAMES - 1);
      BRAKE:   rate_last = 8'(BRAKE_FRAMES - 1);
      default: rate_last = 8'(DECEL_FRAMES - 1);
    endcase

    spd_inc = (speed_q >= 4'(MAX_SPEED)) ? 4'(MAX_SPEED) : speed_q + 4'd1;
    // Floor of 1 keeps the ship drifting whenever it is in flight.
    spd_dec = (speed_q <= 4'd1) ? 4'd1 : speed_q - 4'd1;

    turn_key       = (bus.keycode == KEY_CCW) || (bus.keycode == KEY_CW);
    heading_turned = (bus.keycode == KEY_CW) ? heading_q + 3'd1 : heading_q - 3'd1;

    go_east  = (heading_q == 3'd1) || (heading_q == 3'd2) || (heading_q == 3'd3);
    go_west  = (heading_q == 3'd5) || (heading_q == 3'd6) || (heading_q == 3'd7);
    go_north = (heading_q == 3'd7) || (heading_q == 3'd0) || (heading_q == 3'd1);
    go_south = (heading_q == 3'd3) || (heading_q == 3'd4) || (heading_q == 3'd5);

    // WB-bit add/subtract wraps the world for free.
    spd_ext = WB'(speed_q);
    next_x  = ship_x_q;
    next_y  = ship_y_q;
    if (go_east) begin
      next_x = ship_x_q + spd_ext;
    end else if (go_west) begin
      next_x = ship_x_q - spd_ext;
    end
    if (go_south) begin
      next_y = ship_y_q + spd_ext;
    end else if (go_north) begin
      next_y = ship_y_q - spd_ext;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= HALT;
      ship_x_q    <= WB'(START_X);
      ship_y_q    <= WB'(START_Y);
      heading_q   <= 3'd0;
      speed_q     <= 4'd0;
      thrusting_q <= 1'b0;
      rate_cnt    <= 8'd0;
      turn_cnt    <= 8'd0;
    end else begin
      case (state)
        HALT: begin
          if (bus.moving) begin
            state    <= COAST;
            speed_q  <= 4'd1;
            rate_cnt <= 8'd0;
          end
          thrusting_q <= 1'b0;
        end
        default: begin
          if (!bus.moving) begin
            // Heading and position are kept; only motion stops.
            state       <= HALT;
            speed_q     <= 4'd0;
            rate_cnt    <= 8'd0;
            thrusting_q <= 1'b0;
          end else begin
            state       <= req_state;
            thrusting_q <= (req_state == ACCEL);

            if (rate_cnt == rate_last) begin
              rate_cnt <= 8'd0;
              speed_q  <= (state == ACCEL) ? spd_inc : spd_dec;
            end else begin
              rate_cnt <= rate_cnt + 8'd1;
            end
            // A state change restarts the rate period (overrides the above).
            if (req_state != state) begin
              rate_cnt <= 8'd0;
            end

            if (turn_key) begin
              if (turn_cnt == 8'd0) begin
                heading_q <= heading_turned;
                turn_cnt  <= 8'(TURN_FRAMES - 1);
              end else begin
                turn_cnt <= turn_cnt - 8'd1;
              end
            end else begin
              // Releasing the key rearms so the next press turns immediately.
              turn_cnt <= 8'd0;
            end

            ship_x_q <= next_x;
            ship_y_q <= next_y;
          end
        end
      endcase
    end
  end

  assign bus.ship_x    = ship_x_q;
  assign bus.ship_y    = ship_y_q;
  assign bus.heading   = heading_q;
  assign bus.speed     = speed_q;
  assign bus.thrusting = thrusting_q;

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// tb/tb_ship_motion_ctrl.sv - self-checking bench for ship_motion_ctrl

module tb_ship_motion_ctrl;

  typedef logic [27:0] obs_t; // {x[27:18], y[17:8], heading[7:5], speed[4:1], thrusting[0]}

  typedef struct {
    logic [7:0] key;
    logic       mov;
    int         reps;
    int         ex;
    int         ey;
    int         eh;
    int         es;
    int         et;
  } vec_t;

  localparam obs_t RESET_OBS = {10'd512, 10'd512, 3'd0, 4'd0, 1'b0};

  logic frame_clk;
  logic Reset;

  ship_motion_ctrl_if #(.WB(10)) bus ();

  ship_motion_ctrl #(
    .WB(10), .START_X(512), .START_Y(512), .MAX_SPEED(4),
    .ACCEL_FRAMES(4), .BRAKE_FRAMES(2), .DECEL_FRAMES(8), .TURN_FRAMES(6)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int total = 0;
  int bad   = 0;
  obs_t sb_q[$];

  // Reference model: 0=HALT 1=COAST 2=ACCEL 3=BRAKE
  int m_state, m_x, m_y, m_h, m_s, m_rate, m_turn, m_thr;

  task automatic model_reset();
    m_state = 0; m_x = 512; m_y = 512; m_h = 0; m_s = 0;
    m_rate = 0; m_turn = 0; m_thr = 0;
  endtask

  task automatic model_step(input logic [7:0] key, input logic mov);
    int nst, ns, nr, nt, nh, nx, ny, per, dx, dy;
    nst = m_state; ns = m_s; nr = m_rate; nt = m_turn; nh = m_h; nx = m_x; ny = m_y;
    if (m_state == 0) begin
      if (mov) begin nst = 1; ns = 1; nr = 0; end
    end else if (!mov) begin
      nst = 0; ns = 0; nr = 0;
    end else begin
      if (key == 8'h1A) nst = 2;
      else if (key == 8'h16) nst = 3;
      else nst = 1;
      per = (m_state == 2) ? 4 : (m_state == 3) ? 2 : 8;
      if (m_rate == per - 1) begin
        nr = 0;
        if (m_state == 2) ns = (m_s + 1 > 4) ? 4 : m_s + 1;
        else ns = (m_s - 1 < 1) ? 1 : m_s - 1;
      end else begin
        nr = m_rate + 1;
      end
      if (nst != m_state) nr = 0;
      if (key == 8'h04 || key == 8'h07) begin
        if (m_turn == 0) begin
          nh = (m_h + ((key == 8'h07) ? 1 : 7)) % 8;
          nt = 5;
        end else begin
          nt = m_turn - 1;
        end
      end else begin
        nt = 0;
      end
      case (m_h)
        0: begin dx =  0; dy = -1; end
        1: begin dx =  1; dy = -1; end
        2: begin dx =  1; dy =  0; end
        3: begin dx =  1; dy =  1; end
        4: begin dx =  0; dy =  1; end
        5: begin dx = -1; dy =  1; end
        6: begin dx = -1; dy =  0; end
        default: begin dx = -1; dy = -1; end
      endcase
      nx = ((m_x + dx * m_s) % 1024 + 1024) % 1024;
      ny = ((m_y + dy * m_s) % 1024 + 1024) % 1024;
    end
    m_state = nst; m_s = ns; m_rate = nr; m_turn = nt; m_h = nh; m_x = nx; m_y = ny;
    m_thr = (nst == 2) ? 1 : 0;
  endtask

  function automatic obs_t model_obs();
    return {10'(m_x), 10'(m_y), 3'(m_h), 4'(m_s), 1'(m_thr)};
  endfunction

  function automatic obs_t dut_obs();
    return {bus.ship_x, bus.ship_y, bus.heading, bus.speed, bus.thrusting};
  endfunction

  task automatic cmp(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got x=%0d y=%0d hd=%0d spd=%0d thr=%0d, want x=%0d y=%0d hd=%0d spd=%0d thr=%0d",
               name, act[27:18], act[17:8], act[7:5], act[4:1], act[0],
               exp[27:18], exp[17:8], exp[7:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic step(input logic [7:0] key, input logic mov);
    bus.keycode = key;
    bus.moving  = mov;
    model_step(key, mov);
    sb_q.push_back(model_obs());
    @(posedge frame_clk);
    #1;
    cmp("scoreboard", dut_obs(), sb_q.pop_front());
  endtask

  vec_t tbl[22];
  logic [7:0] rand_keys[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int xb, yb;
    bit hit;

    // key, moving, reps, then expected x, y, heading, speed, thrusting after the reps
    tbl[0]  = '{8'h1A, 1'b0, 20, 512, 512, 0, 0, 0}; // idle: thrust ignored
    tbl[1]  = '{8'h00, 1'b1,  1, 512, 512, 0, 1, 0}; // start: COAST speed 1
    tbl[2]  = '{8'h00, 1'b1,  1, 512, 511, 0, 1, 0}; // first move north
    tbl[3]  = '{8'h00, 1'b1,  3, 512, 508, 0, 1, 0};
    tbl[4]  = '{8'h1A, 1'b1,  1, 512, 507, 0, 1, 1}; // edge k: thrusting
    tbl[5]  = '{8'h1A, 1'b1,  4, 512, 503, 0, 2, 1}; // k+4: speed 2
    tbl[6]  = '{8'h1A, 1'b1,  4, 512, 495, 0, 3, 1}; // k+8: speed 3
    tbl[7]  = '{8'h1A, 1'b1,  4, 512, 483, 0, 4, 1}; // k+12: speed 4
    tbl[8]  = '{8'h1A, 1'b1,  4, 512, 467, 0, 4, 1}; // k+16: still 4
    tbl[9]  = '{8'h00, 1'b1,  1, 512, 463, 0, 4, 0}; // release -> COAST
    tbl[10] = '{8'h00, 1'b1,  8, 512, 431, 0, 3, 0}; // 8 frames later: 3
    tbl[11] = '{8'h16, 1'b1,  1, 512, 428, 0, 3, 0}; // BRAKE entry
    tbl[12] = '{8'h16, 1'b1,  2, 512, 422, 0, 2, 0};
    tbl[13] = '{8'h16, 1'b1,  4, 512, 416, 0, 1, 0}; // floor at 1
    tbl[14] = '{8'h07, 1'b1,  1, 512, 415, 1, 1, 0}; // CW turn on edge 1
    tbl[15] = '{8'h07, 1'b1,  5, 517, 410, 1, 1, 0}; // edges 2..6 no turn
    tbl[16] = '{8'h07, 1'b1,  1, 518, 409, 2, 1, 0}; // edge 7 turns
    tbl[17] = '{8'h07, 1'b1,  6, 524, 409, 3, 1, 0}; // edge 13 turns
    tbl[18] = '{8'h00, 1'b1,  1, 525, 410, 3, 1, 0}; // release rearms
    tbl[19] = '{8'h04, 1'b1,  1, 526, 411, 2, 1, 0}; // CCW on first edge
    tbl[20] = '{8'h00, 1'b0,  1, 526, 411, 2, 0, 0}; // moving drops: HALT
    tbl[21] = '{8'h1A, 1'b0,  3, 526, 411, 2, 0, 0}; // stays frozen

    rand_keys[0] = 8'h04; rand_keys[1] = 8'h07; rand_keys[2] = 8'h1A;
    rand_keys[3] = 8'h16; rand_keys[4] = 8'h00; rand_keys[5] = 8'h33;

    Reset = 1'b1;
    bus.keycode = 8'h00;
    bus.moving  = 1'b0;
    model_reset();
    @(posedge frame_clk);
    @(posedge frame_clk);
    #1;
    cmp("reset_state", dut_obs(), RESET_OBS);
    Reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) step(tbl[i].key, tbl[i].mov);
      cmp($sformatf("vec%0d", i), dut_obs(),
          {10'(tbl[i].ex), 10'(tbl[i].ey), 3'(tbl[i].eh), 4'(tbl[i].es), 1'(tbl[i].et)});
    end

    // Random key/moving traffic checked against the model
    for (int i = 0; i < 200; i++) begin
      step(rand_keys[$urandom_range(0, 5)], ($urandom_range(0, 19) != 0));
    end
    step(8'h1A, 1'b1);
    step(8'h1A, 1'b1);
    step(8'h1A, 1'b1);

    // Asynchronous reset mid-flight, between clock edges
    #3;
    Reset = 1'b1;
    #1;
    cmp("async_reset", dut_obs(), RESET_OBS);
    @(posedge frame_clk);
    #1;
    cmp("reset_held", dut_obs(), RESET_OBS);
    Reset = 1'b0;
    model_reset();
    step(8'h1A, 1'b0);
    cmp("after_reset_idle", dut_obs(), RESET_OBS);

    // Vertical wrap: heading N, speed 1, from y=512 down to 0 then 1023
    step(8'h00, 1'b1);
    for (int i = 0; i < 600 && m_y != 0; i++) step(8'h00, 1'b1);
    hit = (m_y == 0);
    if (!hit) begin
      total++; bad++;
      $display("FAIL wrap_y_reach: got model y=%0d, want 0 within budget", m_y);
    end else begin
      step(8'h00, 1'b1);
      cmp("wrap_y", dut_obs(), {10'd512, 10'd1023, 3'd0, 4'd1, 1'b0});
    end

    // Horizontal wrap: turn to E, thrust to speed 4, cross x=1023
    step(8'h07, 1'b1);
    step(8'h00, 1'b1);
    step(8'h07, 1'b1);
    for (int i = 0; i < 2000 && !(m_s == 4 && m_x >= 1020 && m_h == 2); i++) step(8'h1A, 1'b1);
    hit = (m_s == 4 && m_x >= 1020 && m_h == 2);
    if (!hit) begin
      total++; bad++;
      $display("FAIL wrap_x_reach: got model x=%0d spd=%0d hd=%0d, want x>=1020 spd=4 hd=2", m_x, m_s, m_h);
    end else begin
      xb = m_x;
      yb = m_y;
      step(8'h1A, 1'b1);
      cmp("wrap_x", dut_obs(), {10'(xb + 4 - 1024), 10'(yb), 3'd2, 4'd4, 1'b1});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ship_motion_ctrl.md
Name: ship_motion_ctrl

Overview:
- Player-ship motion stage. Sits directly downstream of the keyboard "moving" latch.
- Consumes the raw keycode byte plus the latched moving flag once per frame_clk. Produces the ship's heading, speed and wrapped world position for the viewport/scroll and sprite stages.
- Keys: 0x04 (A) rotate CCW, 0x07 (D) rotate CW, 0x1A (W) thrust, 0x16 (S) brake. Any other keycode means no key.

Parameters:
- WB, 10, width of each world coordinate; the world is 2^WB square and wraps naturally.
- START_X, 512, reset X position.
- START_Y, 512, reset Y position.
- MAX_SPEED, 4, speed ceiling in pixels/frame per axis (4-bit field).
- ACCEL_FRAMES, 4, frames per +1 speed while thrusting.
- BRAKE_FRAMES, 2, frames per -1 speed while braking.
- DECEL_FRAMES, 8, frames per -1 speed while coasting.
- TURN_FRAMES, 6, frames between heading steps while a turn key is held.

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- keycode  in  8  current USB keycode; single key at a time.
- moving  in  1  sticky "game started" flag from the upstream latch.
- ship_x  out  WB  world X.
- ship_y  out  WB  world Y; 0 is the top edge.
- heading  out  3  0=N, 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW (clockwise).
- speed  out  4  current speed, 0..MAX_SPEED.
- thrusting  out  1  high while state==ACCEL (drives the exhaust sprite).

Behaviour:
- Reset is asynchronous, active-high; clock is frame_clk. Reset values:
  - ship_x=START_X, ship_y=START_Y, heading=0, speed=0, thrusting=0.
  - state=HALT; internal rate_cnt=0 and turn_cnt=0.
- FSM states: HALT, COAST, ACCEL, BRAKE.
- HALT:
  - Position, heading and speed are frozen; speed=0.
  - When moving=1: next state COAST, speed<=1 on that same edge.
- Non-HALT next state:
  - moving=0 -> HALT; speed<=0 on that edge; position holds.
  - else keycode 0x1A -> ACCEL; 0x16 -> BRAKE; anything else -> COAST.
  - rate_cnt<=0 on any state change.
- Speed rules (per edge, evaluated on the current registered state; one-frame lag by design):
  - ACCEL: if rate_cnt==ACCEL_FRAMES-1 then speed<=min(speed+1, MAX_SPEED) and rate_cnt<=0; else rate_cnt++.
  - BRAKE: same pattern with BRAKE_FRAMES; speed decrements, floor 1.
  - COAST: same pattern with DECEL_FRAMES; speed decrements, floor 1.
  - Speed never drops below 1 outside HALT; the ship always drifts, arcade-style.
- Turning (only when state!=HALT):
  - keycode 0x04 or 0x07 with turn_cnt==0: heading<=heading-1 (CCW) or heading+1 (CW), mod 8; turn_cnt<=TURN_FRAMES-1.
  - Turn key held with turn_cnt!=0: turn_cnt--.
  - No turn key: turn_cnt<=0, so the next press turns on its first edge.
- Position (only when state!=HALT), using registered heading and speed from before the edge:
  - dx = +speed for E/NE/SE, -speed for W/NW/SW, 0 for N/S.
  - dy = -speed for N/NE/NW, +speed for S/SE/SW, 0 for E/W.
  - Diagonals move speed on both axes.
  - Add is modulo 2^WB (wrap-around, no clamp): y=0 moving N becomes 2^WB-speed.
- Latency: a keycode change affects state/heading on the next edge; it affects position one edge later.
- Reset mid-flight: all outputs return to reset values immediately (asynchronously). Motion resumes only after moving=1 is sampled.
- moving dropping mid-flight: HALT on the next edge, speed 0, heading retained.

Test Plan:
- Reset asserted mid-flight -> immediately ship_x=512, ship_y=512, heading=0, speed=0, thrusting=0.
- moving=0, keycode=0x1A for 20 frames -> all outputs remain at reset values.
- moving=1, keycode=0x00:
  - Edge 1: COAST, speed=1.
  - Edge 2: ship_y=511.
  - Each subsequent edge: ship_y decrements by 1.
- Speed ramp from COAST at speed 1, then keycode=0x1A held from edge k:
  - Edge k: thrusting=1.
  - Speed 2 at k+4, 3 at k+8, 4 at k+12; still 4 at k+16.
  - Release: speed 3 eight frames after the COAST entry.
- Turn cadence: heading 0, moving=1, keycode=0x07 held 13 edges -> heading steps on edges 1, 7 and 13 to final heading=3. Then keycode=0x04 pressed once -> heading=2 on the first edge.
- Vertical wrap: heading=0, speed=1, ship_y=0 -> next edge ship_y=1023.
- Horizontal wrap: heading=2, speed=4, ship_x=1022 -> next edge ship_x=2.
